fp_addsub_pipe: RTL and testbench

//  Parametrised, 3-stage pipelined floating-point add/subtract unit with valid/ready handshake.

---
 rtl/fp_pkg.sv | 40 ++++
 rtl/fp_lzc.sv | 24 ++
 rtl/fp_addsub_pipe.sv | 199 +++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point add/subtract unit:
// default format widths, guard/round/sticky positions and field helpers.
package fp_pkg;

  localparam int unsigned EXP_W_DEF  = 5;
  localparam int unsigned FRAC_W_DEF = 10;

  // Extra low-order bits carried below the fraction during alignment
  localparam int unsigned GRS_W = 3;
  localparam int unsigned G_POS = 2;
  localparam int unsigned R_POS = 1;
  localparam int unsigned S_POS = 0;

  function automatic logic [31:0] fp_exp(input logic [63:0] w,
                                         input int unsigned frac_w,
                                         input int unsigned exp_w);
    logic [63:0] mask;
    mask = (64'd1 << exp_w) - 64'd1;
    return 32'((w >> frac_w) & mask);
  endfunction

  function automatic logic [63:0] fp_frac(input logic [63:0] w,
                                          input int unsigned frac_w);
    return w & ((64'd1 << frac_w) - 64'd1);
  endfunction

  function automatic logic fp_sign(input logic [63:0] w,
                                   input int unsigned frac_w,
                                   input int unsigned exp_w);
    return w[frac_w + exp_w];
  endfunction

  // A zero exponent encodes zero regardless of the fraction bits
  function automatic logic fp_is_zero(input logic [63:0] w,
                                      input int unsigned frac_w,
                                      input int unsigned exp_w);
    return fp_exp(w, frac_w, exp_w) == 32'd0;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fp_lzc #(
  parameter int unsigned W = 14
) (
  input  logic [W-1:0]           data,
  output logic [$clog2(W+1)-1:0] count_c
);

  localparam int unsigned CNT_W = $clog2(W + 1);

  logic found;

  always_comb begin
    count_c = CNT_W'(W);
    found   = 1'b0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (!found && data[i]) begin
        count_c = CNT_W'(int'(W) - 1 - i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point add/subtract (align, add, normalise/round) with
// round-to-nearest-even, overflow saturation and underflow flush-to-zero.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W  = EXP_W_DEF,
  parameter int unsigned FRAC_W = FRAC_W_DEF,
  parameter int unsigned DATA_W = 1 + EXP_W + FRAC_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_op,
  input  logic [DATA_W-1:0] i_data_a,
  input  logic [DATA_W-1:0] i_data_b,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_overflow,
  output logic              o_underflow,
  output logic              o_zero
);

  localparam int unsigned M_W     = FRAC_W + 1 + GRS_W;
  localparam int unsigned SUM_W   = M_W + 1;
  localparam int unsigned SE_W    = EXP_W + 2;
  localparam int unsigned LZ_W    = $clog2(M_W + 1);
  localparam int unsigned RND_W   = FRAC_W + 2;
  localparam int unsigned KEY_W   = EXP_W + FRAC_W;
  localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

  logic en;

  assign en      = !o_valid || i_ready;
  assign o_ready = en;

  // ---------------- S1: unpack, swap, align ----------------
  logic              sa, sb, za, zb, swap;
  logic [EXP_W-1:0]  ea, eb, l_e, s_e, d;
  logic [FRAC_W-1:0] fa, fb;
  logic [KEY_W-1:0]  key_a, key_b;
  logic [M_W-1:0]    ma, mb, l_m, s_raw, s_al, lost;
  logic              l_s;

  assign ea = EXP_W'(fp_exp(64'(i_data_a), FRAC_W, EXP_W));
  assign eb = EXP_W'(fp_exp(64'(i_data_b), FRAC_W, EXP_W));
  assign fa = FRAC_W'(fp_frac(64'(i_data_a), FRAC_W));
  assign fb = FRAC_W'(fp_frac(64'(i_data_b), FRAC_W));
  assign sa = fp_sign(64'(i_data_a), FRAC_W, EXP_W);
  assign sb = fp_sign(64'(i_data_b), FRAC_W, EXP_W) ^ i_op;
  assign za = fp_is_zero(64'(i_data_a), FRAC_W, EXP_W);
  assign zb = fp_is_zero(64'(i_data_b), FRAC_W, EXP_W);

  always_comb begin
    key_a = {ea, za ? FRAC_W'(0) : fa};
    key_b = {eb, zb ? FRAC_W'(0) : fb};
    ma    = za ? M_W'(0) : {1'b1, fa, GRS_W'(0)};
    mb    = zb ? M_W'(0) : {1'b1, fb, GRS_W'(0)};
    swap  = key_b > key_a;
    l_m   = swap ? mb : ma;
    s_raw = swap ? ma : mb;
    l_e   = swap ? eb : ea;
    s_e   = swap ? ea : eb;
    l_s   = swap ? sb : sa;
    d     = l_e - s_e;
    lost  = '0;
    s_al  = '0;
    // Far-out operands collapse entirely into the sticky bit
    if (32'(d) >= FRAC_W + 3) begin
      s_al[S_POS] = |s_raw;
    end else begin
      lost        = s_raw & ((M_W'(1) << d) - M_W'(1));
      s_al        = s_raw >> d;
      s_al[S_POS] = s_al[S_POS] | (|lost);
    end
  end

  logic             s1_valid, s1_sign, s1_sub;
  logic [M_W-1:0]   s1_l_m, s1_s_m;
  logic [EXP_W-1:0] s1_e;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_sub   <= 1'b0;
      s1_l_m   <= '0;
      s1_s_m   <= '0;
      s1_e     <= '0;
    end else if (en) begin
      s1_valid <= i_valid;
      s1_sign  <= l_s;
      s1_sub   <= sa ^ sb;
      s1_l_m   <= l_m;
      s1_s_m   <= s_al;
      s1_e     <= l_e;
    end
  end

  // ---------------- S2: add/subtract magnitudes, count leading zeros ----------------
  logic [SUM_W-1:0] sum;
  logic [LZ_W-1:0]  lzc;

  assign sum = s1_sub ? ({1'b0, s1_l_m} - {1'b0, s1_s_m})
                      : ({1'b0, s1_l_m} + {1'b0, s1_s_m});

  fp_lzc #(.W(M_W)) u_lzc (
    .data    (sum[M_W-1:0]),
    .count_c (lzc)
  );

  logic             s2_valid, s2_sign;
  logic [SUM_W-1:0] s2_sum;
  logic [LZ_W-1:0]  s2_lzc;
  logic [EXP_W-1:0] s2_e;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_sum   <= '0;
      s2_lzc   <= '0;
      s2_e     <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_sum   <= sum;
      s2_lzc   <= lzc;
      s2_e     <= s1_e;
    end
  end

  // ---------------- S3: normalise, round, range check ----------------
  logic signed [SE_W-1:0] e_n, e_r;
  logic [M_W-1:0]         norm_m;
  logic [FRAC_W:0]        keep;
  logic [RND_W-1:0]       rnd;
  logic [FRAC_W-1:0]      frac_r;
  logic                   round_up;
  logic [DATA_W-1:0]      res_data;
  logic                   res_ov, res_uf, res_zero;

  always_comb begin
    if (s2_sum[SUM_W-1]) begin
      norm_m = {s2_sum[SUM_W-1:2], s2_sum[1] | s2_sum[0]};
      e_n    = $signed({2'b00, s2_e}) + $signed(SE_W'(1));
    end else begin
      norm_m = s2_sum[M_W-1:0] << s2_lzc;
      e_n    = $signed({2'b00, s2_e}) - $signed(SE_W'(s2_lzc));
    end
    keep     = norm_m[M_W-1:GRS_W];
    round_up = norm_m[G_POS] & (norm_m[R_POS] | norm_m[S_POS] | keep[0]);
    rnd      = {1'b0, keep} + RND_W'(round_up);
    // Mantissa overflow from rounding leaves 1.000 one binade up
    if (rnd[RND_W-1]) begin
      frac_r = '0;
      e_r    = e_n + $signed(SE_W'(1));
    end else begin
      frac_r = rnd[FRAC_W-1:0];
      e_r    = e_n;
    end

    res_data = {s2_sign, EXP_W'(e_r), frac_r};
    res_ov   = 1'b0;
    res_uf   = 1'b0;
    res_zero = 1'b0;
    if (s2_sum == '0) begin
      res_data = '0;
      res_zero = 1'b1;
    end else if (e_r > $signed(SE_W'(EXP_MAX))) begin
      res_data = {s2_sign, {(DATA_W-1){1'b1}}};
      res_ov   = 1'b1;
    end else if (e_r < $signed(SE_W'(1))) begin
      res_data = '0;
      res_uf   = 1'b1;
      res_zero = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
      o_zero      <= 1'b0;
    end else if (en) begin
      o_valid <= s2_valid;
      if (s2_valid) begin
        o_data      <= res_data;
        o_overflow  <= res_ov;
        o_underflow <= res_uf;
        o_zero      <= res_zero;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe (EXP_W=5, FRAC_W=10): directed vectors, stall, reset
// and random traffic against an exact-arithmetic reference model.
module tb_fp_addsub_pipe;

  logic        clk, rst_n;
  logic        in_valid, in_op, out_ready_dn;
  logic [15:0] data_a, data_b;
  logic        ready_up, out_valid, ovf, unf, zro;
  logic [15:0] res;

  fp_addsub_pipe dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (in_valid),
    .o_ready     (ready_up),
    .i_op        (in_op),
    .i_data_a    (data_a),
    .i_data_b    (data_b),
    .o_valid     (out_valid),
    .i_ready     (out_ready_dn),
    .o_data      (res),
    .o_overflow  (ovf),
    .o_underflow (unf),
    .o_zero      (zro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [18:0] exp_q[$];
  logic        hold_pend = 1'b0;
  logic [18:0] held = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Exact sum in scaled integers, then correctly rounded to 11 significant bits
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic op);
    longint va, vb, r, q, rem, half;
    int     p, sh, e;
    logic   s;
    va = 0;
    vb = 0;
    if (a[14:10] != 5'd0) va = longint'({1'b1, a[9:0]}) << (a[14:10] - 1);
    if (b[14:10] != 5'd0) vb = longint'({1'b1, b[9:0]}) << (b[14:10] - 1);
    if (a[15]) va = -va;
    if (b[15] ^ op) vb = -vb;
    r = va + vb;
    if (r == 0) return {16'h0000, 3'b001};
    s = (r < 0);
    if (s) r = -r;
    p = 0;
    for (int i = 0; i < 64; i++) if (((r >> i) & 1) == 1) p = i;
    sh = p - 10;
    if (sh > 0) begin
      q    = r >> sh;
      rem  = r - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == 2048) begin
        q  = 1024;
        sh = sh + 1;
      end
    end else begin
      q = r << (-sh);
    end
    e = sh + 1;
    if (e > 31) return {s, 15'h7FFF, 3'b100};
    if (e < 1) return {16'h0000, 3'b011};
    return {s, 5'(e), 10'(q), 3'b000};
  endfunction

  function automatic logic [31:0] rnd_pair();
    logic [15:0] a, b;
    a = 16'($urandom);
    b = 16'($urandom);
    case ($urandom_range(0, 3))
      1: b[14:10] = a[14:10] ^ 5'($urandom_range(0, 3));
      2: b[14:0]  = a[14:0] ^ 15'($urandom_range(0, 7));
      3: if ($urandom_range(0, 1) == 0) b[14:10] = 5'd0; else a[14:10] = 5'd0;
      default: ;
    endcase
    return {a, b};
  endfunction

  // One clock: drive, check any departing result and output stability, log acceptance
  task automatic cycle(input logic v, input logic op, input logic [15:0] a,
                       input logic [15:0] b, input logic rdy, input logic use_k,
                       input logic [18:0] k, output logic acc);
    logic [18:0] obs;
    @(negedge clk);
    in_valid = v; in_op = op; data_a = a; data_b = b; out_ready_dn = rdy;
    #1;
    obs = {res, ovf, unf, zro};
    if (hold_pend) chk("hold_stable", {12'h0, out_valid, obs}, {12'h0, 1'b1, held});
    if (out_valid && out_ready_dn) begin
      if (exp_q.size() == 0) chk("unexpected_valid", 32'(out_valid), 32'd0);
      else chk("result", 32'(obs), 32'(exp_q.pop_front()));
    end
    hold_pend = out_valid && !out_ready_dn;
    held      = obs;
    acc       = v && ready_up;
    if (acc) exp_q.push_back(use_k ? k : model(a, b, op));
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++)
      cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 19'h0, acc);
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  logic [15:0] dir_a[8]  = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00,
                             16'h7FFF, 16'hFFFF, 16'h0401, 16'h0000};
  logic [15:0] dir_b[8]  = '{16'h3C00, 16'h3C00, 16'h1000, 16'h1200,
                             16'h7FFF, 16'hFFFF, 16'h0400, 16'hC000};
  logic        dir_op[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [18:0] dir_k[8]  = '{{16'h4000, 3'b000}, {16'h0000, 3'b001},
                             {16'h3C00, 3'b000}, {16'h3C01, 3'b000},
                             {16'h7FFF, 3'b100}, {16'hFFFF, 3'b100},
                             {16'h0000, 3'b011}, {16'hC000, 3'b000}};

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc, rdy, v;
    logic [31:0] pr;
    logic [15:0] st_a[5], st_b[5];
    int          c, sent;

    rst_n = 1'b0; in_valid = 1'b0; in_op = 1'b0;
    data_a = '0; data_b = '0; out_ready_dn = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", {12'h0, out_valid, res, ovf, unf, zro}, 32'h0);
    rst_n = 1'b1;

    // Latency: accepted in cycle 0, visible in cycle 3
    @(negedge clk);
    in_valid = 1'b1; in_op = 1'b0; data_a = 16'h3C00; data_b = 16'h3C00;
    #1 chk("lat_ready", 32'(ready_up), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_c1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_c2", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_c3", {12'h0, out_valid, res, ovf, unf, zro}, {12'h0, 1'b1, 16'h4000, 3'b000});
    @(negedge clk);
    chk("lat_c4", 32'(out_valid), 32'd0);

    // Directed vectors back to back
    for (int i = 0; i < 8; i++)
      cycle(1'b1, dir_op[i], dir_a[i], dir_b[i], 1'b1, 1'b1, dir_k[i], acc);
    drain();

    // Five-op stream with the sink stalled in cycles 2..6
    for (int i = 0; i < 5; i++) begin
      pr = rnd_pair();
      st_a[i] = pr[31:16];
      st_b[i] = pr[15:0];
    end
    c = 0;
    sent = 0;
    while ((sent < 5 || c <= 6) && c < 40) begin
      rdy = !(c >= 2 && c <= 6);
      v   = sent < 5;
      cycle(v, 1'(c & 1), st_a[sent % 5], st_b[sent % 5], rdy, 1'b0, 19'h0, acc);
      if (!rdy && out_valid) chk("stall_ready", 32'(ready_up), 32'd0);
      if (acc) sent++;
      c++;
    end
    chk("stall_all_sent", 32'(sent), 32'd5);
    drain();

    // Asynchronous reset with the pipe full
    for (int i = 0; i < 4; i++) begin
      pr = rnd_pair();
      cycle(1'b1, 1'b0, pr[31:16], pr[15:0], 1'b0, 1'b0, 19'h0, acc);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {12'h0, out_valid, res, ovf, unf, zro}, 32'h0);
    exp_q.delete();
    hold_pend = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 19'h0, acc);
    cycle(1'b1, 1'b0, 16'h3C00, 16'h1200, 1'b1, 1'b1, {16'h3C01, 3'b000}, acc);
    drain();

    // Random traffic with random bubbles and back-pressure
    for (int i = 0; i < 500; i++) begin
      pr = rnd_pair();
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), pr[31:16], pr[15:0],
            1'($urandom_range(0, 3) != 0), 1'b0, 19'h0, acc);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
